mul_unit: RTL



---
 rtl/mul_unit_if.sv | 24 ++
 rtl/mul_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/mul_unit_if.sv
// Request/response bundle between the register file ports and the multiply unit.
// The master issues operands and a destination; the slave (mul_unit) returns the write-back.
interface mul_unit_if #(parameter int WIDTH = 64);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;
  logic [4:0]       RdIn;
  logic [WIDTH-1:0] Result;
  logic [4:0]       RdOut;
  logic             RegWr;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Op, BusA, BusB, RdIn,
    input  Result, RdOut, RegWr, Busy, Done
  );

  modport slave (
    input  Start, Op, BusA, BusB, RdIn,
    output Result, RdOut, RegWr, Busy, Done
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier: MUL, UMULH and SMULH with a fixed 64-cycle run
// and a single-cycle register-file write strobe.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | one multiplier bit consumed per cycle (count 0..WIDTH-1)
// DONE  | Result/RdOut valid, RegWr strobed; Start here re-enters RUN
module mul_unit #(
  parameter int WIDTH = 64
) (
  input logic         Clk,
  input logic         ResetL,
  mul_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, stateNext;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcandSh;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [1:0]         opLat;
  logic [4:0]         rdLat;
  logic [WIDTH-1:0]   result;
  logic [4:0]         rdOut;

  logic               accept;
  logic               lastIter;
  logic               isSigned;
  logic               highSel;
  logic [WIDTH-1:0]   absA, absB;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] prodFinal;

  always_comb begin
    accept    = bus.Start && (state == IDLE || state == DONE);
    lastIter  = (state == RUN) && (count == CW'(WIDTH - 1));
    isSigned  = (bus.Op == 2'b10);
    highSel   = (opLat == 2'b01) || (opLat == 2'b10);
    // The most negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    absA      = bus.BusA[WIDTH-1] ? -bus.BusA : bus.BusA;
    absB      = bus.BusB[WIDTH-1] ? -bus.BusB : bus.BusB;
    accNext   = acc + (mplier[0] ? mcandSh : '0);
    prodFinal = neg ? -accNext : accNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = RUN;
      RUN:     if (lastIter) stateNext = DONE;
      DONE:    stateNext = accept ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      mcandSh <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      opLat   <= 2'b00;
      rdLat   <= '0;
      result  <= '0;
      rdOut   <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        mcandSh <= {{WIDTH{1'b0}}, (isSigned ? absA : bus.BusA)};
        mplier  <= isSigned ? absB : bus.BusB;
        neg     <= isSigned && (bus.BusA[WIDTH-1] ^ bus.BusB[WIDTH-1]);
        opLat   <= bus.Op;
        rdLat   <= bus.RdIn;
        acc     <= '0;
        count   <= '0;
      end else if (state == RUN) begin
        // Shifting the multiplicand left and the multiplier right replaces the indexed add.
        acc     <= accNext;
        mcandSh <= mcandSh << 1;
        mplier  <= mplier >> 1;
        count   <= count + 1'b1;
        if (lastIter) begin
          result <= highSel ? prodFinal[2*WIDTH-1:WIDTH] : prodFinal[WIDTH-1:0];
          rdOut  <= rdLat;
        end
      end
    end
  end

  assign bus.Result = result;
  assign bus.RdOut  = rdOut;
  assign bus.Busy   = (state == RUN);
  assign bus.Done   = (state == DONE);
  assign bus.RegWr  = (state == DONE);
endmodule
